// File: rtl/dqn_fixed_pkg.sv
// Shared Q6.10 fixed-point definitions for the DQN training datapath.
package dqn_fixed_pkg;

    localparam int unsigned Q_W    = 16;
    localparam int unsigned Q_FRAC = 10;
    localparam int          Q_ONE  = 1024;

    typedef logic signed [Q_W-1:0] q_t;

    localparam q_t Q_MAX = q_t'(32767);
    localparam q_t Q_MIN = q_t'(-32768);

    // Saturate a wide signed intermediate into the q_t range.
    function automatic q_t sat_q(input logic signed [31:0] x);
        if (x > 32'(Q_MAX)) begin
            return Q_MAX;
        end
        if (x < 32'(Q_MIN)) begin
            return Q_MIN;
        end
        return q_t'(x);
    endfunction

endpackage

// File: rtl/td_delta_unit_q_max_scan.sv
// Next-state Q-value scanner: ready/valid handshake, sample counter and
// signed running max. done_c marks the handshake of the final sample and
// max_c is the max including the sample currently on q_in.
module q_max_scan
    import dqn_fixed_pkg::*;
#(
    parameter int unsigned N_ACTIONS = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           en,
    input  logic [Q_W-1:0] q_in,
    input  logic           q_in_valid,
    output logic [Q_W-1:0] max_c,
    output logic           done_c
);

    localparam int unsigned CNT_W = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1;

    logic [CNT_W-1:0] cnt;
    q_t               max_r;
    logic             hs_c;
    logic             first_c;
    q_t               q_in_s;

    assign q_in_s  = q_t'(q_in);
    assign hs_c    = en & q_in_valid;
    assign first_c = (cnt == '0);
    assign max_c   = (first_c || (q_in_s > max_r)) ? q_in_s : max_r;
    assign done_c  = hs_c && (cnt == CNT_W'(N_ACTIONS - 1));

    // Count accepted samples and track the strictly-greater running max.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt   <= '0;
            max_r <= '0;
        end else if (hs_c) begin
            cnt   <= done_c ? '0 : cnt + CNT_W'(1);
            max_r <= max_c;
        end
    end

endmodule

// File: rtl/td_delta_unit.sv
// TD error generator: delta = sat(reward + GAMMA*max(Q_next) - q_cur), Q6.10.
// Optional macro TD_DELTA_CLIP_EN clamps delta to [-1.0, +1.0].
// The discounted product is registered on the last sample handshake so the
// saturated sum lands two cycles after that handshake.
module td_delta_unit
    import dqn_fixed_pkg::*;
#(
    parameter int unsigned N_ACTIONS = 4,
    parameter q_t          GAMMA     = 16'sd1014
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic signed [Q_W-1:0] reward,
    input  logic                  terminal,
    input  logic signed [Q_W-1:0] q_cur,
    input  logic signed [Q_W-1:0] q_in,
    input  logic                  q_in_valid,
    output logic                  q_in_ready,
    output logic signed [Q_W-1:0] delta,
    output logic                  delta_valid,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        MUL  = 2'd2
    } state_t;

    state_t              state;
    q_t                  reward_r;
    q_t                  q_cur_r;
    logic                terminal_r;
    logic signed [16:0]  disc;

    logic                scan_clear_c;
    logic                scan_done_c;
    logic [Q_W-1:0]      scan_max_raw_c;
    q_t                  scan_max_c;
    logic signed [31:0]  prod_c;
    logic signed [16:0]  disc_c;
    logic signed [17:0]  sum_c;
    q_t                  sat_c;
    q_t                  delta_c;

    assign scan_clear_c = (state == IDLE) && start;

    q_max_scan #(
        .N_ACTIONS (N_ACTIONS)
    ) u_scan (
        .clk        (clk),
        .rst        (rst),
        .clear      (scan_clear_c),
        .en         (q_in_ready),
        .q_in       (q_in),
        .q_in_valid (q_in_valid),
        .max_c      (scan_max_raw_c),
        .done_c     (scan_done_c)
    );

    // Discounted max: floor((qmax * GAMMA) / 2^Q_FRAC) via arithmetic shift.
    assign scan_max_c = q_t'(scan_max_raw_c);
    assign prod_c     = 32'(scan_max_c) * 32'(GAMMA);
    assign disc_c     = 17'(prod_c >>> Q_FRAC);

    // Wide sum cannot overflow; saturate back to q_t.
    assign sum_c = 18'(reward_r) + 18'(disc) - 18'(q_cur_r);
    assign sat_c = sat_q(32'(sum_c));

`ifdef TD_DELTA_CLIP_EN
    localparam q_t CLIP_HI = q_t'(Q_ONE);
    localparam q_t CLIP_LO = q_t'(-Q_ONE);

    // Huber-style gradient clip to +/-1.0 after saturation.
    always_comb begin
        delta_c = sat_c;
        if (sat_c > CLIP_HI) begin
            delta_c = CLIP_HI;
        end else if (sat_c < CLIP_LO) begin
            delta_c = CLIP_LO;
        end
    end
`else
    assign delta_c = sat_c;
`endif

    // Transaction sequencing with registered handshake, busy and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            reward_r    <= '0;
            q_cur_r     <= '0;
            terminal_r  <= 1'b0;
            disc        <= '0;
            delta       <= '0;
            delta_valid <= 1'b0;
            busy        <= 1'b0;
            q_in_ready  <= 1'b0;
        end else begin
            delta_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        reward_r   <= reward;
                        q_cur_r    <= q_cur;
                        terminal_r <= terminal;
                        q_in_ready <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_done_c) begin
                        disc       <= terminal_r ? 17'sd0 : disc_c;
                        q_in_ready <= 1'b0;
                        state      <= MUL;
                    end
                end
                MUL: begin
                    delta       <= delta_c;
                    delta_valid <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_td_delta_unit.sv
// Bench for td_delta_unit: directed and randomized transactions against an
// arithmetic reference model. Honours TD_DELTA_CLIP_EN when defined.
module tb_td_delta_unit;

    localparam int N = 4;
    localparam int G = 1014;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [15:0] reward;
    logic               terminal;
    logic signed [15:0] q_cur;
    logic signed [15:0] q_in;
    logic               q_in_valid;
    logic               q_in_ready;
    logic signed [15:0] delta;
    logic               delta_valid;
    logic               busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_hs = 0;
    int hs_cnt  = 0;
    int dv_cyc  = 0;
    int dv_cnt  = 0;

    td_delta_unit #(.N_ACTIONS(N), .GAMMA(16'sd1014)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .reward      (reward),
        .terminal    (terminal),
        .q_cur       (q_cur),
        .q_in        (q_in),
        .q_in_valid  (q_in_valid),
        .q_in_ready  (q_in_ready),
        .delta       (delta),
        .delta_valid (delta_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record handshakes and result pulses mid-cycle.
    always @(negedge clk) begin
        if (q_in_valid && q_in_ready) begin
            last_hs = cyc;
            hs_cnt++;
        end
        if (delta_valid) begin
            dv_cyc = cyc;
            dv_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    // Reference: TD target from the rules, with explicit floor division.
    function automatic int model(input int r, input int qc, input bit term,
                                 input int s[4]);
        int mx;
        int p;
        int disc;
        int sum;
        mx = s[0];
        for (int i = 1; i < N; i++) if (s[i] > mx) mx = s[i];
        p = mx * G;
        if (term)        disc = 0;
        else if (p >= 0) disc = p / 1024;
        else             disc = -((-p + 1023) / 1024);
        sum = r + disc - qc;
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
`ifdef TD_DELTA_CLIP_EN
        if (sum > 1024)  sum = 1024;
        if (sum < -1024) sum = -1024;
`endif
        return sum;
    endfunction

    // One transaction; entered and left at posedge+1.
    task automatic run_txn(input string tag, input int r, input int qc,
                           input bit term, input int s[4], input int gap_pct,
                           input bit extra_starts);
        int exp;
        int t0;
        int dv0;
        int hs0;
        int guard;
        bit ok;
        exp = model(r, qc, term, s);
        dv0 = dv_cnt;
        hs0 = hs_cnt;
        reward   = 16'(r);
        q_cur    = 16'(qc);
        terminal = term;
        start    = 1'b1;
        @(negedge clk);
        t0 = cyc;
        chk({tag, "_idle_at_start"}, busy, 0);
        @(posedge clk); #1;
        start  = 1'b0;
        reward = 16'($urandom);
        q_cur  = 16'($urandom);
        for (int i = 0; i < N; i++) begin
            guard = 0;
            while (($urandom_range(99) < gap_pct) && guard < 8) begin
                q_in_valid = 1'b0;
                q_in       = 16'($urandom);
                if (extra_starts && $urandom_range(1) == 1) begin
                    start    = 1'b1;
                    reward   = 16'($urandom);
                    terminal = ~term;
                end
                @(posedge clk); #1;
                start    = 1'b0;
                terminal = term;
                guard++;
            end
            q_in       = 16'(s[i]);
            q_in_valid = 1'b1;
            guard      = 0;
            do begin
                @(negedge clk);
                ok = q_in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!ok && guard < 20);
            chk({tag, "_sample_accepted"}, ok, 1);
        end
        q_in_valid = 1'b0;
        guard = 0;
        while (dv_cnt == dv0 && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        chk({tag, "_dv_seen"}, dv_cnt - dv0, 1);
        chk({tag, "_delta"}, delta, exp);
        chk({tag, "_samples"}, hs_cnt - hs0, N);
        chk({tag, "_lat_from_hs"}, dv_cyc - last_hs, 2);
        if (gap_pct == 0) chk({tag, "_lat_from_start"}, dv_cyc - t0, N + 2);
        chk({tag, "_busy_done"}, busy, 0);
        repeat (3) @(negedge clk);
        chk({tag, "_one_dv"}, dv_cnt - dv0, 1);
        chk({tag, "_delta_held"}, delta, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        int s[4];
        int dv0;
        rst = 1'b1; start = 1'b0; reward = '0; terminal = 1'b0;
        q_cur = '0; q_in = '0; q_in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        @(negedge clk);
        chk("rst_delta", delta, 0);
        chk("rst_dv", delta_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", q_in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        s = '{512, 2048, 1000, -300};
        run_txn("basic", 1024, 1536, 1'b0, s, 0, 1'b0);
`ifdef TD_DELTA_CLIP_EN
        chk("basic_const", delta, 1024);
`else
        chk("basic_const", delta, 1516);
`endif

        s = '{rnd16(), rnd16(), rnd16(), rnd16()};
        run_txn("terminal", 1024, 512, 1'b1, s, 0, 1'b0);
        chk("terminal_const", delta, 512);

        s = '{-100, -50, -200, -75};
        run_txn("neg_floor", 0, 0, 1'b0, s, 0, 1'b0);
        chk("neg_floor_const", delta, -50);

        s = '{32767, 32767, 32767, 32767};
        run_txn("sat_hi", 31744, -32768, 1'b0, s, 0, 1'b0);
        s = '{-32768, -32768, -32768, -32768};
        run_txn("sat_lo", -32768, 32767, 1'b0, s, 0, 1'b0);

        s = '{512, 2048, 1000, -300};
        run_txn("stall", 1024, 1536, 1'b0, s, 40, 1'b1);

        // Abort mid-scan after two samples.
        dv0 = dv_cnt;
        reward = 16'sd1024; q_cur = 16'sd1536; terminal = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        q_in = 16'sd512;  q_in_valid = 1'b1;
        @(posedge clk); #1;
        q_in = 16'sd2048;
        @(posedge clk); #1;
        q_in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_delta", delta, 0);
        chk("abort_dv", delta_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", q_in_ready, 0);
        repeat (6) @(negedge clk);
        chk("abort_no_dv", dv_cnt - dv0, 0);
        @(posedge clk); #1;
        s = '{512, 2048, 1000, -300};
        run_txn("after_abort", 1024, 1536, 1'b0, s, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            s = '{rnd16(), rnd16(), rnd16(), rnd16()};
            run_txn("random", rnd16(), rnd16(), ($urandom_range(3) == 0),
                    s, 25, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/td_delta_unit.md
# td_delta_unit

Temporal-difference error generator for the DQN training datapath. Scans the next-state Q-values streamed out of the target network, forms the TD target `r + GAMMA*max(Q_next)`, and subtracts the current-state Q-value to produce the signed Q6.10 error `delta`. `delta` feeds directly into the bias-gradient stage, which latches it and scales it by the learning rate.

## Interface
Parameters:
- `N_ACTIONS`, default 4: number of next-state Q-values scanned per transaction (≥1).
- `GAMMA`, default 16'sd1014: discount factor in Q6.10 (≈0.99).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle request; sampled only in IDLE
- `reward`  in  16 signed  Q6.10 reward; latched on accepted `start`
- `terminal`  in  1  episode-end flag; latched on accepted `start`
- `q_cur`  in  16 signed  Q6.10 Q(s,a); latched on accepted `start`
- `q_in`  in  16 signed  Q6.10 next-state Q-value stream
- `q_in_valid`  in  1  `q_in` valid
- `q_in_ready`  out  1  high only in SCAN
- `delta`  out  16 signed  Q6.10 TD error; held until next result
- `delta_valid`  out  1  one-cycle pulse when `delta` updates
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, SCAN, MUL, ADD.
- IDLE: on `start`, latch `reward`, `terminal`, `q_cur`; clear sample counter; go to SCAN. `start` outside IDLE is ignored.
- SCAN: a sample is accepted when `q_in_valid && q_in_ready`. The first sample initialises the running max; later samples replace it only when strictly greater (signed compare). After the `N_ACTIONS`-th accepted sample, go to MUL. Gaps in `q_in_valid` stall without penalty.
- Terminal transitions still consume all `N_ACTIONS` samples, but the discounted term is forced to 0.
- MUL: compute the 32-bit signed product `qmax*GAMMA`, then arithmetic shift right by 10 (floor). Register the result as 17-bit `disc`. Go to ADD.
- ADD: compute the 18-bit signed sum `reward + disc - q_cur`. Saturate to [-32768, 32767] and register it into `delta`. Pulse `delta_valid`. Return to IDLE.
- Reset values: `delta`=0, `delta_valid`=0, `busy`=0, `q_in_ready`=0, state IDLE, running max 0, counter 0.
- `rst` mid-transaction: abort immediately to IDLE; the partial result is discarded and no `delta_valid` is produced.

## Timing
- `start` accepted at cycle 0 → SCAN from cycle 1.
- With back-to-back samples, the last sample is accepted at cycle N_ACTIONS; MUL at N_ACTIONS+1; `delta`/`delta_valid` registered and visible at N_ACTIONS+2.
- General rule: `delta_valid` rises exactly 2 cycles after the last sample handshake.
- The earliest next `start` is accepted in the cycle `delta_valid` is high (state already IDLE). This gives a minimum throughput of N_ACTIONS+2 cycles per transaction.
- `q_in_ready` is a registered-state decode: high from the cycle after `start` until the cycle of the last handshake, inclusive.

## Configuration
- `TD_DELTA_CLIP_EN` defined: after saturation, `delta` is clamped to [-1024, 1024] (±1.0, Huber-style gradient clip). The clamp is in the same ADD cycle, so latency is unchanged.
- Undefined: `delta` is only saturated to the 16-bit range.

## Structure
- Shared package `dqn_fixed_pkg` holds:
  - constants `Q_W`=16, `Q_FRAC`=10, `Q_ONE`=1024, `Q_MAX`, `Q_MIN`;
  - typedef `q_t` (signed 16-bit);
  - the saturate-to-`q_t` function, also reused by the weight/bias update stages.
- FSM state enum is local to the block.
- One natural sub-module: `q_max_scan` (handshake, sample counter, running max, done pulse). The FSM, multiply and add stay in `td_delta_unit`.

## Test plan
- Basic: `reward`=1024, `q_cur`=1536, `terminal`=0, samples {512, 2048, 1000, -300} → `delta`=1516, `delta_valid` at cycle 6 (N=4, no gaps).
- Terminal: `reward`=1024, `q_cur`=512, `terminal`=1, any 4 samples → `delta`=512. All 4 samples must still be accepted.
- Negative max with floor rounding: samples {-100, -50, -200, -75}, `reward`=0, `q_cur`=0 → `delta`=-50.
- Saturation: `reward`=31744, all samples 32767, `q_cur`=-32768 → 32767. Then `reward`=-32768, samples -32768, `q_cur`=32767 → -32768.
- Stall and ignore: random `q_in_valid` gaps plus `start` pulses while busy → same `delta` as the gap-free run, exactly one `delta_valid`. Extra `start` pulses have no effect.
- Reset mid-SCAN after 2 samples → all outputs return to reset values, no `delta_valid`. A following clean transaction completes correctly. With `TD_DELTA_CLIP_EN`, the basic case yields `delta`=1024.
